// File: rtl/pmp_scan_ctrl.sv
// Sequential PMP checker: one address comparator walks entries 0..N-1, one entry per cycle.
// pmpaddr is a byte address: TOR covers [pmpaddr[i-1], pmpaddr[i]); NA4 covers the aligned word;
// NAPOT covers 2^(k+1) bytes, where k is the number of trailing ones. The whole access must fit.
module pmp_scan_ctrl #(
    parameter int unsigned PMP_ENTRIES = 16,
    localparam int unsigned IDX_W = $clog2(PMP_ENTRIES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_size,
    input  logic [1:0]                req_type,
    input  logic                      req_mmode,
    input  logic [8*PMP_ENTRIES-1:0]  pmpcfg_i,
    input  logic [32*PMP_ENTRIES-1:0] pmpaddr_i,
    output logic                      busy,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic                      resp_allow,
    output logic                      resp_matched,
    output logic [IDX_W-1:0]          resp_idx
);
    localparam int unsigned LAST_IDX = PMP_ENTRIES - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       type_q, type_d;
    logic             mmode_q, mmode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] resp_idx_q, resp_idx_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_allow_q, resp_allow_d;
    logic             resp_matched_q, resp_matched_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;

    logic [IDX_W-1:0] prev_idx;
    logic [31:0]      addr_n;
    logic [31:0]      addr_n_1;
    logic [1:0]       a_n;
    logic [2:0]       rwx_n;
    logic             lock_n;
    logic [32:0]      end_w;
    logic [31:0]      napot_mask;
    logic             hit_c;
    logic             perm_c;

    // Shared address checker for the entry currently selected by idx_q
    always_comb begin
        prev_idx   = idx_q - IDX_W'(1);
        addr_n     = pmpaddr_i[32*int'(idx_q) +: 32];
        addr_n_1   = (idx_q == '0) ? 32'h0 : pmpaddr_i[32*int'(prev_idx) +: 32];
        a_n        = pmpcfg_i[8*int'(idx_q)+3 +: 2];
        rwx_n      = pmpcfg_i[8*int'(idx_q) +: 3];
        lock_n     = pmpcfg_i[8*int'(idx_q)+7];
        napot_mask = ~(addr_n ^ (addr_n + 32'd1));
        case (size_q)
            2'b01:   end_w = {1'b0, addr_q} + 33'd1;
            2'b11:   end_w = {1'b0, addr_q} + 33'd3;
            default: end_w = {1'b0, addr_q};
        endcase
        case (a_n)
            2'b01:   hit_c = (addr_q >= addr_n_1) && (end_w < {1'b0, addr_n});
            2'b10:   hit_c = (addr_q[31:2] == addr_n[31:2]) &&
                             (end_w[32:2] == {1'b0, addr_n[31:2]});
            2'b11:   hit_c = !end_w[32] &&
                             ((addr_q & napot_mask) == (addr_n & napot_mask)) &&
                             ((end_w[31:0] & napot_mask) == (addr_n & napot_mask));
            default: hit_c = 1'b0;
        endcase
        case (type_q)
            2'b00:   perm_c = rwx_n[0];
            2'b01:   perm_c = rwx_n[1];
            default: perm_c = rwx_n[2];
        endcase
    end

    // Next-state and response logic
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        type_d         = type_q;
        mmode_d        = mmode_q;
        idx_d          = idx_q;
        resp_idx_d     = resp_idx_q;
        resp_allow_d   = resp_allow_q;
        resp_matched_d = resp_matched_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    type_d  = req_type;
                    mmode_d = req_mmode;
                    idx_d   = '0;
                    if (req_size == 2'b10 || req_type == 2'b11) begin
                        state_d        = RESP;
                        resp_allow_d   = 1'b0;
                        resp_matched_d = 1'b0;
                        resp_idx_d     = '0;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (hit_c) begin
                    state_d        = RESP;
                    resp_matched_d = 1'b1;
                    resp_idx_d     = idx_q;
                    resp_allow_d   = (mmode_q && !lock_n) ? 1'b1 : perm_c;
                end else if (idx_q == IDX_W'(LAST_IDX)) begin
                    state_d        = RESP;
                    resp_matched_d = 1'b0;
                    resp_idx_d     = '0;
                    resp_allow_d   = mmode_q;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_valid_d = (state_d == RESP);
        busy_d       = (state_d != IDLE);
        req_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            size_q         <= '0;
            type_q         <= '0;
            mmode_q        <= 1'b0;
            idx_q          <= '0;
            resp_idx_q     <= '0;
            resp_valid_q   <= 1'b0;
            resp_allow_q   <= 1'b0;
            resp_matched_q <= 1'b0;
            busy_q         <= 1'b0;
            req_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            size_q         <= size_d;
            type_q         <= type_d;
            mmode_q        <= mmode_d;
            idx_q          <= idx_d;
            resp_idx_q     <= resp_idx_d;
            resp_valid_q   <= resp_valid_d;
            resp_allow_q   <= resp_allow_d;
            resp_matched_q <= resp_matched_d;
            busy_q         <= busy_d;
            req_ready_q    <= req_ready_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_allow   = resp_allow_q;
    assign resp_matched = resp_matched_q;
    assign resp_idx     = resp_idx_q;

endmodule

// File: tb/tb_pmp_scan_ctrl.sv
// Bench for pmp_scan_ctrl with 4 entries: directed cases plus random requests checked
// against a region-arithmetic model of the PMP rules.
module tb_pmp_scan_ctrl;
    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic [1:0]    req_type;
    logic          req_mmode;
    logic [8*N-1:0]  pmpcfg_i;
    logic [32*N-1:0] pmpaddr_i;
    logic          busy;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_allow;
    logic          resp_matched;
    logic [1:0]    resp_idx;

    logic [7:0]  cfg_m [N];
    logic [31:0] pa_m  [N];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            pmpcfg_i[8*i +: 8]   = cfg_m[i];
            pmpaddr_i[32*i +: 32] = pa_m[i];
        end
    end

    pmp_scan_ctrl #(.PMP_ENTRIES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_size(req_size), .req_type(req_type), .req_mmode(req_mmode),
        .pmpcfg_i(pmpcfg_i), .pmpaddr_i(pmpaddr_i),
        .busy(busy), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_allow(resp_allow), .resp_matched(resp_matched), .resp_idx(resp_idx)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte regions per entry, first fully-containing region wins
    function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                                  input logic mm, output logic m, output int idx,
                                  output logic al, output int lat);
        longint lo, hi, s, e, span;
        int k, nb;
        m = 1'b0; idx = 0; al = 1'b0;
        if (sz == 2'b10 || ty == 2'b11) begin
            lat = 1;
            return;
        end
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        s = longint'({32'h0, a});
        e = s + nb - 1;
        for (int i = 0; i < N; i++) begin
            lo = 0; hi = -1;
            case (cfg_m[i][4:3])
                2'b01: begin
                    lo = (i == 0) ? 0 : longint'({32'h0, pa_m[i-1]});
                    hi = longint'({32'h0, pa_m[i]}) - 1;
                end
                2'b10: begin
                    lo = longint'({32'h0, pa_m[i]}) / 4 * 4;
                    hi = lo + 3;
                end
                2'b11: begin
                    k = 0;
                    while (k < 32 && pa_m[i][k]) k++;
                    span = longint'(1) << (k + 1);
                    lo = longint'({32'h0, pa_m[i]}) / span * span;
                    hi = lo + span - 1;
                end
                default: ;
            endcase
            if (s >= lo && e <= hi) begin
                m = 1'b1;
                idx = i;
                if (mm && !cfg_m[i][7]) al = 1'b1;
                else al = cfg_m[i][ty];
                lat = 2 + i;
                return;
            end
        end
        al = mm;
        lat = 1 + N;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request, check latency, response, stability under backpressure and return to idle
    task automatic run_req(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                           input logic mm, input int hold);
        logic em, eal;
        int eidx, elat, lat, n;
        model(a, sz, ty, mm, em, eidx, eal, elat);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_addr = a; req_size = sz; req_type = ty; req_mmode = mm;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, elat);
        if (!resp_valid) begin
            $display("FAIL resp_timeout: no resp_valid after %0d cycles", lat);
            do_reset();
            return;
        end
        chk("matched", resp_matched, em);
        chk("idx", resp_idx, eidx);
        chk("allow", resp_allow, eal);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_addr = $urandom;
            req_size = 2'($urandom);
            req_type = 2'($urandom);
            @(negedge clk);
            chk("hold_state", {resp_valid, resp_matched, resp_allow, resp_idx, req_ready},
                {1'b1, em, eal, 2'(eidx), 1'b0});
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("idle_after_resp", {resp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        logic pm, pal;
        int pidx, plat;
        logic [31:0] base, a;
        int k, hit_any;

        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_type = '0;
        req_mmode = 1'b0; resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin cfg_m[i] = '0; pa_m[i] = '0; end

        // Reset
        @(negedge clk);
        chk("reset_outs", {resp_valid, busy, resp_matched, resp_allow, resp_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);

        // TOR
        cfg_m[1] = 8'h09; pa_m[0] = 32'h1234566E; pa_m[1] = 32'h1234567E;
        model(32'h1234566E, 2'b00, 2'b00, 1'b0, pm, pidx, pal, plat);
        chk("pin_tor", {pm, 2'(pidx), pal, 4'(plat)}, {1'b1, 2'd1, 1'b1, 4'd3});
        run_req(32'h1234566E, 2'b00, 2'b00, 1'b0, 0);
        run_req(32'h1234566E, 2'b00, 2'b01, 1'b0, 0);
        run_req(32'h1234567D, 2'b01, 2'b00, 1'b0, 0);

        // No match
        for (int i = 0; i < N; i++) cfg_m[i] = '0;
        model(32'h1234566E, 2'b00, 2'b00, 1'b0, pm, pidx, pal, plat);
        chk("pin_nomatch_u", {pm, 2'(pidx), pal, 4'(plat)}, {1'b0, 2'd0, 1'b0, 4'd5});
        model(32'h1234566E, 2'b00, 2'b00, 1'b1, pm, pidx, pal, plat);
        chk("pin_nomatch_m", {pm, 2'(pidx), pal, 4'(plat)}, {1'b0, 2'd0, 1'b1, 4'd5});
        run_req(32'h1234566E, 2'b00, 2'b00, 1'b0, 0);
        run_req(32'h1234566E, 2'b00, 2'b00, 1'b1, 0);

        // Priority with lock
        cfg_m[0] = 8'h93; pa_m[0] = 32'h80000010;
        cfg_m[2] = 8'h1F; pa_m[2] = 32'h8000001F;
        model(32'h80000010, 2'b11, 2'b10, 1'b1, pm, pidx, pal, plat);
        chk("pin_prio", {pm, 2'(pidx), pal, 4'(plat)}, {1'b1, 2'd0, 1'b0, 4'd2});
        run_req(32'h80000010, 2'b11, 2'b10, 1'b1, 0);
        run_req(32'h80000020, 2'b11, 2'b10, 1'b0, 0);

        // Backpressure
        run_req(32'h80000010, 2'b11, 2'b00, 1'b0, 10);

        // Reserved encodings
        model(32'h80000010, 2'b10, 2'b00, 1'b0, pm, pidx, pal, plat);
        chk("pin_rsvd", {pm, 2'(pidx), pal, 4'(plat)}, {1'b0, 2'd0, 1'b0, 4'd1});
        run_req(32'h80000010, 2'b10, 2'b00, 1'b1, 0);
        run_req(32'h80000010, 2'b00, 2'b11, 1'b1, 2);

        // Reset mid-scan
        for (int i = 0; i < N; i++) cfg_m[i] = '0;
        req_valid = 1'b1; req_addr = 32'h40; req_size = 2'b00; req_type = 2'b00; req_mmode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs", {resp_valid, busy}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        hit_any = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid || busy) hit_any = 1;
        end
        chk("abort_no_resp", hit_any, 0);
        chk("abort_ready", req_ready, 1);

        // Random
        for (int t = 0; t < 150; t++) begin
            base = $urandom & 32'hFFFFFF00;
            for (int i = 0; i < N; i++) begin
                cfg_m[i] = {($urandom_range(0, 3) == 0), 2'b00, 2'($urandom), 3'($urandom)};
                case (cfg_m[i][4:3])
                    2'b11: begin
                        k = $urandom_range(0, 7);
                        pa_m[i] = (base & ~((32'd1 << (k + 1)) - 1)) | ((32'd1 << k) - 1);
                    end
                    default: pa_m[i] = base + 32'($urandom_range(0, 80));
                endcase
            end
            a = base + 32'($urandom_range(0, 96));
            run_req(a, 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
